// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store) for one req/gnt/r_valid memory port.
// Define ARB_ROUND_ROBIN_EN for alternating grants under contention; default is data > instr.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  CLK,
  input  logic                  RES,
  input  logic                  instr_req,
  input  logic [ADDR_W-1:0]     instr_addr,
  output logic                  instr_gnt,
  output logic                  instr_r_valid,
  output logic [DATA_W-1:0]     instr_rdata,
  input  logic                  data_req,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic                  data_we,
  input  logic [DATA_W/8-1:0]   data_be,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_gnt,
  output logic                  data_r_valid,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_r_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  arb_busy,
  output logic [3:0]            arb_debug
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t state;
  logic   owner;   // 0 = instr, 1 = data
  logic   last;    // most recently granted requester
  logic   any_req;
  logic   win;
  logic   sel;
  logic   sel_req;
  logic   rsp;

  always_comb begin
    any_req = instr_req | data_req;
`ifdef ARB_ROUND_ROBIN_EN
    win = (instr_req && data_req) ? ~last : data_req;
`else
    win = data_req;
`endif
    // In IDLE the port follows the live winner; afterwards it is locked to the owner.
    sel     = (state == IDLE) ? win : owner;
    sel_req = sel ? data_req : instr_req;

    mem_req = 1'b0;
    if (!RES) begin
      case (state)
        IDLE:     mem_req = any_req;
        WAIT_GNT: mem_req = sel_req;
        default:  mem_req = 1'b0;
      endcase
    end

    mem_addr  = sel ? data_addr : instr_addr;
    mem_we    = sel & data_we;
    mem_be    = sel ? data_be : '1;
    mem_wdata = sel ? data_wdata : '0;

    instr_gnt = mem_req & mem_gnt & ~sel;
    data_gnt  = mem_req & mem_gnt & sel;

    rsp           = !RES && (state == WAIT_RSP) && mem_r_valid;
    instr_r_valid = rsp & ~owner;
    data_r_valid  = rsp & owner;
    instr_rdata   = mem_rdata;
    data_rdata    = mem_rdata;

    arb_busy  = !RES && (state != IDLE);
    arb_debug = {owner, last, state};
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= win;
            if (mem_gnt) begin
              last  <= win;
              state <= WAIT_RSP;
            end else begin
              state <= WAIT_GNT;
            end
          end
        end
        WAIT_GNT: begin
          // A request withdrawn before its grant aborts the transaction.
          if (!sel_req) begin
            state <= IDLE;
          end else if (mem_gnt) begin
            last  <= owner;
            state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_r_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model. Honors ARB_ROUND_ROBIN_EN like the design.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          CLK = 1'b0;
  logic          RES;
  logic          instr_req, instr_gnt, instr_r_valid;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr_rdata;
  logic          data_req, data_we, data_gnt, data_r_valid;
  logic [AW-1:0] data_addr;
  logic [BW-1:0] data_be;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          mem_req, mem_we, mem_gnt, mem_r_valid;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          arb_busy;
  logic [3:0]    arb_debug;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RES(RES),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_r_valid(instr_r_valid), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_we(data_we), .data_be(data_be),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_r_valid(data_r_valid),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_r_valid(mem_r_valid),
    .mem_rdata(mem_rdata), .arb_busy(arb_busy), .arb_debug(arb_debug)
  );

  // Reference model: one outstanding response (pend/rsp_who) or one claimed-but-
  // ungranted request (claim_v/claim_who); otherwise the port is free.
  bit   pend, claim_v, rsp_who, claim_who;
  bit   last_w = 1'b1;
  logic pick;
  logic exp_sel, exp_mem_req, exp_igt, exp_dgt, exp_irv, exp_drv, exp_busy;
  logic [5:0] exp_ctl;
  logic [AW+1+BW+DW-1:0] exp_bus;

  always @* begin
`ifdef ARB_ROUND_ROBIN_EN
    pick = (instr_req && data_req) ? ~last_w : data_req;
`else
    pick = data_req;
`endif
    exp_sel     = pend ? rsp_who : (claim_v ? claim_who : pick);
    exp_mem_req = !RES && !pend && (claim_v ? (claim_who ? data_req : instr_req)
                                            : (instr_req || data_req));
    exp_igt  = exp_mem_req && mem_gnt && !exp_sel;
    exp_dgt  = exp_mem_req && mem_gnt && exp_sel;
    exp_irv  = !RES && pend && mem_r_valid && !rsp_who;
    exp_drv  = !RES && pend && mem_r_valid && rsp_who;
    exp_busy = !RES && (pend || claim_v);
    exp_ctl  = {exp_mem_req, exp_igt, exp_dgt, exp_irv, exp_drv, exp_busy};
    exp_bus  = exp_sel ? {data_addr, data_we, data_be, data_wdata}
                       : {instr_addr, 1'b0, {BW{1'b1}}, {DW{1'b0}}};
  end

  always @(posedge CLK) begin
    bit w;
    w = pick;
    if (RES) begin
      pend = 0; claim_v = 0; last_w = 1'b1;
    end else if (pend) begin
      if (mem_r_valid) pend = 0;
    end else if (claim_v) begin
      if (!(claim_who ? data_req : instr_req)) claim_v = 0;
      else if (mem_gnt) begin
        pend = 1; rsp_who = claim_who; last_w = claim_who; claim_v = 0;
      end
    end else if (instr_req || data_req) begin
      if (mem_gnt) begin
        pend = 1; rsp_who = w; last_w = w;
      end else begin
        claim_v = 1; claim_who = w;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req = 0; data_req = 0; data_we = 0; mem_gnt = 0; mem_r_valid = 0;
  endtask

  task automatic test_reset();
    RES = 1; instr_req = 1; instr_addr = 32'h40; mem_gnt = 0;
    repeat (2) begin
      @(negedge CLK);
      n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      n_vec++; if (instr_gnt !== 1'b0) begin n_err++; $display("FAIL reset_instr_gnt: got %b want 0", instr_gnt); end
      n_vec++; if (arb_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", arb_busy); end
      tick();
    end
    RES = 0;
    @(negedge CLK);
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL release_mem_req: got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 32'h40) begin n_err++; $display("FAIL release_mem_addr: got %h want 00000040", mem_addr); end
    tick();
    instr_req = 0;
    tick();
  endtask

  task automatic test_single_fetch();
    instr_req = 1; instr_addr = 32'h100; mem_gnt = 1;
    @(negedge CLK);
    n_vec++; if (instr_gnt !== 1'b1) begin n_err++; $display("FAIL fetch_gnt: got %b want 1", instr_gnt); end
    n_vec++; if ({mem_addr, mem_we, mem_be} !== {32'h100, 1'b0, 4'hF})
      begin n_err++; $display("FAIL fetch_bus: got %h/%b/%h want 00000100/0/f", mem_addr, mem_we, mem_be); end
    tick();
    instr_req = 0; mem_gnt = 0;
    @(negedge CLK);
    n_vec++; if ({instr_r_valid, arb_busy, mem_req} !== 3'b010)
      begin n_err++; $display("FAIL fetch_wait: got %b want 010", {instr_r_valid, arb_busy, mem_req}); end
    tick();
    mem_r_valid = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge CLK);
    n_vec++; if (instr_r_valid !== 1'b1 || data_r_valid !== 1'b0)
      begin n_err++; $display("FAIL fetch_rvalid: got %b%b want 10", instr_r_valid, data_r_valid); end
    n_vec++; if (instr_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL fetch_rdata: got %h want deadbeef", instr_rdata); end
    tick();
    mem_r_valid = 0;
    @(negedge CLK);
    n_vec++; if (arb_busy !== 1'b0) begin n_err++; $display("FAIL fetch_idle: got %b want 0", arb_busy); end
    tick();
  endtask

  task automatic test_contention();
    instr_req = 1; instr_addr = 32'h200;
    data_req = 1; data_addr = 32'h300; data_we = 1; data_be = 4'h3; data_wdata = 32'h12345678;
    mem_gnt = 1;
    @(negedge CLK);
    n_vec++; if ({data_gnt, instr_gnt} !== 2'b10) begin n_err++; $display("FAIL cont_first: got %b want 10", {data_gnt, instr_gnt}); end
    n_vec++; if ({mem_addr, mem_we, mem_be, mem_wdata} !== {32'h300, 1'b1, 4'h3, 32'h12345678})
      begin n_err++; $display("FAIL cont_bus: got %h/%b/%h/%h", mem_addr, mem_we, mem_be, mem_wdata); end
    tick();
    data_req = 0;
    @(negedge CLK);
    n_vec++; if ({instr_gnt, mem_req} !== 2'b00) begin n_err++; $display("FAIL cont_hold: got %b want 00", {instr_gnt, mem_req}); end
    tick();
    mem_r_valid = 1;
    @(negedge CLK);
    n_vec++; if ({data_r_valid, instr_r_valid, instr_gnt} !== 3'b100)
      begin n_err++; $display("FAIL cont_rsp: got %b want 100", {data_r_valid, instr_r_valid, instr_gnt}); end
    tick();
    mem_r_valid = 0;
    @(negedge CLK);
    n_vec++; if ({instr_gnt, mem_addr, mem_we} !== {1'b1, 32'h200, 1'b0})
      begin n_err++; $display("FAIL cont_second: got %b/%h/%b want 1/00000200/0", instr_gnt, mem_addr, mem_we); end
    tick();
    instr_req = 0; mem_gnt = 0; mem_r_valid = 1;
    @(negedge CLK);
    n_vec++; if (instr_r_valid !== 1'b1) begin n_err++; $display("FAIL cont_second_rsp: got %b want 1", instr_r_valid); end
    tick();
    idle_inputs();
  endtask

  task automatic test_alternation();
    logic [1:0] who;
    logic [1:0] want;
    RES = 1; idle_inputs();
    tick();
    RES = 0;
    instr_req = 1; instr_addr = 32'h1000; data_req = 1; data_addr = 32'h2000; mem_gnt = 1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      want = (k % 2 == 0) ? 2'd0 : 2'd1;
`else
      want = 2'd1;
`endif
      @(negedge CLK);
      who = data_gnt ? 2'd1 : (instr_gnt ? 2'd0 : 2'd2);
      n_vec++; if (who !== want) begin n_err++; $display("FAIL alt_grant_%0d: got %0d want %0d", k, who, want); end
      tick();
      mem_r_valid = 1;
      tick();
      mem_r_valid = 0;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_abort();
    logic [DW-1:0] rd;
    instr_req = 1; instr_addr = 32'h500; mem_gnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      n_vec++; if ({mem_req, instr_gnt} !== 2'b10) begin n_err++; $display("FAIL stall_%0d: got %b want 10", k, {mem_req, instr_gnt}); end
      tick();
    end
    instr_req = 0;
    @(negedge CLK);
    n_vec++; if ({mem_req, arb_busy} !== 2'b01) begin n_err++; $display("FAIL abort_drop: got %b want 01", {mem_req, arb_busy}); end
    tick();
    @(negedge CLK);
    n_vec++; if ({mem_req, arb_busy} !== 2'b00) begin n_err++; $display("FAIL abort_idle: got %b want 00", {mem_req, arb_busy}); end
    tick();
    data_req = 1; data_addr = 32'h600; data_we = 0; mem_gnt = 1;
    @(negedge CLK);
    n_vec++; if ({data_gnt, mem_addr} !== {1'b1, 32'h600}) begin n_err++; $display("FAIL abort_next_gnt: got %b/%h", data_gnt, mem_addr); end
    tick();
    rd = $urandom;
    data_req = 0; mem_gnt = 0; mem_r_valid = 1; mem_rdata = rd;
    @(negedge CLK);
    n_vec++; if ({data_r_valid, data_rdata} !== {1'b1, rd}) begin n_err++; $display("FAIL abort_next_rsp: got %b/%h want 1/%h", data_r_valid, data_rdata, rd); end
    tick();
    idle_inputs();
  endtask

  task automatic test_spurious();
    mem_r_valid = 1;
    @(negedge CLK);
    n_vec++; if ({instr_r_valid, data_r_valid, arb_busy} !== 3'b000)
      begin n_err++; $display("FAIL spur_idle: got %b want 000", {instr_r_valid, data_r_valid, arb_busy}); end
    tick();
    instr_req = 1; instr_addr = 32'h700;
    tick();
    @(negedge CLK);
    n_vec++; if ({instr_r_valid, arb_busy} !== 2'b01) begin n_err++; $display("FAIL spur_wait_gnt: got %b want 01", {instr_r_valid, arb_busy}); end
    mem_r_valid = 0; mem_gnt = 1;
    tick();
    instr_req = 0; mem_gnt = 0; RES = 1;
    @(negedge CLK);
    n_vec++; if ({instr_r_valid, arb_busy} !== 2'b00) begin n_err++; $display("FAIL spur_res: got %b want 00", {instr_r_valid, arb_busy}); end
    tick();
    RES = 0; mem_r_valid = 1;
    @(negedge CLK);
    n_vec++; if ({instr_r_valid, data_r_valid, arb_busy} !== 3'b000)
      begin n_err++; $display("FAIL spur_late_rsp: got %b want 000", {instr_r_valid, data_r_valid, arb_busy}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    logic igt, dgt, was;
    igt = 0; dgt = 0;
    for (int c = 0; c < 600; c++) begin
      RES = ($urandom_range(0, 63) == 0);
      was = instr_req;
      if (instr_req && !igt) instr_req = ($urandom_range(0, 7) != 0);
      else instr_req = $urandom_range(0, 1);
      if (instr_req && (!was || igt)) instr_addr = $urandom;
      was = data_req;
      if (data_req && !dgt) data_req = ($urandom_range(0, 7) != 0);
      else data_req = $urandom_range(0, 1);
      if (data_req && (!was || dgt)) begin
        data_addr = $urandom; data_we = $urandom_range(0, 1);
        data_be = $urandom_range(0, 15); data_wdata = $urandom;
      end
      mem_gnt = $urandom_range(0, 1);
      mem_r_valid = ($urandom_range(0, 4) < 2);
      mem_rdata = $urandom;
      @(negedge CLK);
      igt = instr_gnt; dgt = data_gnt;
      n_vec++; if ({mem_req, instr_gnt, data_gnt, instr_r_valid, data_r_valid, arb_busy} !== exp_ctl)
        begin n_err++; $display("FAIL rand_ctl cyc %0d: got %b want %b", c,
          {mem_req, instr_gnt, data_gnt, instr_r_valid, data_r_valid, arb_busy}, exp_ctl); end
      if (exp_mem_req) begin
        n_vec++; if ({mem_addr, mem_we, mem_be, mem_wdata} !== exp_bus)
          begin n_err++; $display("FAIL rand_bus cyc %0d: got %h want %h", c, {mem_addr, mem_we, mem_be, mem_wdata}, exp_bus); end
      end
      n_vec++; if ({instr_rdata, data_rdata} !== {mem_rdata, mem_rdata})
        begin n_err++; $display("FAIL rand_rdata cyc %0d: got %h/%h want %h", c, instr_rdata, data_rdata, mem_rdata); end
      tick();
    end
    RES = 0;
    idle_inputs();
    tick();
  endtask

  initial begin
    RES = 1;
    idle_inputs();
    instr_addr = '0; data_addr = '0; data_be = '0; data_wdata = '0; mem_rdata = '0;
    tick();
    test_reset();
    test_single_fetch();
    test_contention();
    test_alternation();
    test_abort();
    test_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
